emif_buffer_loader: RTL and testbench

Sequencer that moves a block of data from the external-memory model (emif_inner-style port: combinational read, registered write) into one on-chip input buffer (ml_block_input-style port, 16-bit words). It fetches one wide EMIF line at a time and unpacks it lane by lane into consecutive buffer addresses. It sits between the top-level state machine (start/done) and the buffer write ports, and owns the EMIF address bus while busy.

---
 rtl/emif_loader_pkg.sv | 33 +++
 rtl/line_lane_mux.sv | 31 +++
 rtl/emif_buffer_loader.sv | 155 +++++++++++++++
 tb/tb_emif_buffer_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/emif_loader_pkg.sv
// ============================================================================
//  Package   : emif_loader_pkg
//  Purpose   : Shared state encoding, default widths and lane helper for the
//              EMIF-to-buffer loader.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package emif_loader_pkg;

    localparam int c_def_emif_addr_w = 12;
    localparam int c_def_emif_data_w = 128;
    localparam int c_def_buf_addr_w  = 8;
    localparam int c_def_buf_data_w  = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    function automatic int lanes(input int emif_w, input int buf_w);
        return emif_w / buf_w;
    endfunction

    function automatic bit lanes_ok(input int emif_w, input int buf_w);
        return (buf_w > 0) && ((emif_w % buf_w) == 0) && (emif_w >= buf_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_lane_mux.sv
// ============================================================================
//  Module    : line_lane_mux
//  Purpose   : Selects one word-wide lane out of a captured EMIF line.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_lane_mux #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 16,
    parameter int LANES  = 8,
    parameter int SEL_W  = 3
) (
    input  logic [LINE_W-1:0] i_line,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [WORD_W-1:0] o_word
);

    // Loop form keeps out-of-range selects (non power-of-two lane counts) at zero.
    always_comb begin
        o_word = '0;
        for (int k = 0; k < LANES; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_word = i_line[k*WORD_W +: WORD_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/emif_buffer_loader.sv
// ============================================================================
//  Module    : emif_buffer_loader
//  Purpose   : Fetches EMIF lines and unpacks them lane by lane into an input
//              buffer. Define LOADER_CHECKSUM_EN to add the checksum output.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module emif_buffer_loader
    import emif_loader_pkg::*;
#(
    parameter int EMIF_ADDR_W = c_def_emif_addr_w,
    parameter int EMIF_DATA_W = c_def_emif_data_w,
    parameter int BUF_ADDR_W  = c_def_buf_addr_w,
    parameter int BUF_DATA_W  = c_def_buf_data_w
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EMIF_ADDR_W-1:0] emif_base,
    input  logic [BUF_ADDR_W-1:0]  buf_base,
    input  logic [BUF_ADDR_W:0]    num_words,
    output logic [EMIF_ADDR_W-1:0] emif_address,
    input  logic [EMIF_DATA_W-1:0] emif_dataout,
    output logic                   emif_wen,
    output logic [BUF_ADDR_W-1:0]  buf_addr,
    output logic [BUF_DATA_W-1:0]  buf_datain,
    output logic                   buf_wen,
    output logic                   busy,
    output logic                   done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [BUF_DATA_W-1:0]  checksum
`endif
);

    localparam int c_lanes  = lanes(EMIF_DATA_W, BUF_DATA_W);
    localparam int c_lane_w = (c_lanes > 1) ? $clog2(c_lanes) : 1;
    localparam logic [c_lane_w-1:0]   c_last_lane = c_lane_w'(c_lanes - 1);
    localparam logic [BUF_ADDR_W:0]   c_one_left  = (BUF_ADDR_W+1)'(1);

    if (!lanes_ok(EMIF_DATA_W, BUF_DATA_W)) begin : g_width_check
        $error("EMIF_DATA_W must be an integer multiple of BUF_DATA_W");
    end

    state_t                 r_state;
    logic [EMIF_ADDR_W-1:0] r_line_ptr;
    logic [BUF_ADDR_W-1:0]  r_buf_ptr;
    logic [BUF_ADDR_W:0]    r_remaining;
    logic [EMIF_DATA_W-1:0] r_line;
    logic [c_lane_w-1:0]    r_lane;
    logic                   r_buf_wen;
    logic                   r_busy;
    logic                   r_done;
`ifdef LOADER_CHECKSUM_EN
    logic [BUF_DATA_W-1:0]  r_checksum;
`endif

    logic [BUF_DATA_W-1:0]  w_lane_word;

    line_lane_mux #(
        .LINE_W (EMIF_DATA_W),
        .WORD_W (BUF_DATA_W),
        .LANES  (c_lanes),
        .SEL_W  (c_lane_w)
    ) u_lane_mux (
        .i_line (r_line),
        .i_sel  (r_lane),
        .o_word (w_lane_word)
    );

    // The line pointer doubles as the EMIF address, so it holds outside FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_line_ptr  <= '0;
            r_buf_ptr   <= '0;
            r_remaining <= '0;
            r_line      <= '0;
            r_lane      <= '0;
            r_buf_wen   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_line_ptr  <= emif_base;
                        r_buf_ptr   <= buf_base;
                        r_remaining <= num_words;
                        r_busy      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum  <= '0;
`endif
                        if (num_words == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_line    <= emif_dataout;
                    r_lane    <= '0;
                    r_buf_wen <= 1'b1;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    r_buf_ptr   <= r_buf_ptr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_lane      <= r_lane + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_checksum  <= r_checksum + w_lane_word;
`endif
                    if (r_remaining == c_one_left) begin
                        r_buf_wen <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (r_lane == c_last_lane) begin
                        r_buf_wen  <= 1'b0;
                        r_line_ptr <= r_line_ptr + 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign emif_address = r_line_ptr;
    assign emif_wen     = 1'b0;
    assign buf_addr     = r_buf_ptr;
    assign buf_datain   = w_lane_word;
    assign buf_wen      = r_buf_wen;
    assign busy         = r_busy;
    assign done         = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign checksum     = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_emif_buffer_loader.sv
// ============================================================================
//  Module    : tb_emif_buffer_loader
//  Purpose   : Directed scoreboard bench for emif_buffer_loader.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_emif_buffer_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [11:0]  emif_base = '0;
    logic [7:0]   buf_base = '0;
    logic [8:0]   num_words = '0;
    logic [11:0]  emif_address;
    logic [127:0] emif_dataout;
    logic         emif_wen;
    logic [7:0]   buf_addr;
    logic [15:0]  buf_datain;
    logic         buf_wen;
    logic         busy;
    logic         done;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]  checksum;
`endif

    logic [127:0] mem [0:4095];

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign emif_dataout = mem[emif_address];

    emif_buffer_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .emif_base    (emif_base),
        .buf_base     (buf_base),
        .num_words    (num_words),
        .emif_address (emif_address),
        .emif_dataout (emif_dataout),
        .emif_wen     (emif_wen),
        .buf_addr     (buf_addr),
        .buf_datain   (buf_datain),
        .buf_wen      (buf_wen),
        .busy         (busy),
        .done         (done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every buffer write must match the next expected word.
    always @(negedge clk) begin
        if (!reset && buf_wen) begin
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_write: observed write to %0h, expected no write", buf_addr);
            end
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                check("sb_addr", {120'd0, buf_addr}, {120'd0, mon_e.a});
                check("sb_data", {112'd0, buf_datain}, {112'd0, mon_e.d});
            end
        end
    end

    task automatic push_expected(input logic [11:0] base, input logic [7:0] bb,
                                 input int n, output logic [15:0] sum);
        logic [11:0]  line;
        logic [127:0] ldata;
        exp_t         e;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            line  = base + 12'(i / 8);
            ldata = mem[line];
            e.a   = bb + 8'(i);
            e.d   = ldata[(i % 8)*16 +: 16];
            sum   = sum + e.d;
            q.push_back(e);
        end
    endtask

    task automatic run_load(input string tag, input logic [11:0] base, input logic [7:0] bb,
                            input int n, input bit extra);
        int          d_exp;
        int          cyc;
        int          dones;
        int          done_cyc;
        int          wens;
        logic [15:0] sum;
        push_expected(base, bb, n, sum);
        d_exp = (n + 7) / 8 + n + 1;
        @(negedge clk);
        emif_base = base;
        buf_base  = bb;
        num_words = 9'(n);
        start     = 1'b1;
        cyc = 0; dones = 0; done_cyc = -1; wens = 0;
        while (cyc < d_exp + 3) begin
            @(posedge clk);
            cyc++;
            #1;
            start = extra && (cyc == 4 || cyc == 10);
            emif_base = 12'($urandom);
            buf_base  = 8'($urandom);
            num_words = 9'($urandom_range(1, 256));
            @(negedge clk);
            if (buf_wen) wens++;
            if (done) begin
                dones++;
                done_cyc = cyc;
`ifdef LOADER_CHECKSUM_EN
                check({tag, "_checksum_at_done"}, {112'd0, checksum}, {112'd0, sum});
`endif
            end
            if (cyc == d_exp) check({tag, "_busy_at_done"}, {127'd0, busy}, 128'd1);
            if (cyc == d_exp + 1) check({tag, "_busy_after"}, {127'd0, busy}, 128'd0);
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 128'(done_cyc), 128'(d_exp));
        check({tag, "_done_pulses"}, 128'(dones), 128'd1);
        check({tag, "_wen_cycles"}, 128'(wens), 128'(n));
        check({tag, "_sb_drained"}, 128'(q.size()), 128'd0);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_checksum_stable"}, {112'd0, checksum}, {112'd0, sum});
`endif
        q.delete();
    endtask

    initial begin
        int   cyc;
        int   dones;
        logic [15:0] sum;

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int k = 0; k < 8; k++) begin
            mem[12'h010][k*16 +: 16] = 16'(k);
            mem[12'h020][k*16 +: 16] = 16'hA000 + 16'(k * 16'h0111);
            mem[12'h021][k*16 +: 16] = 16'hB000 + 16'(k * 16'h0123);
            mem[12'hFFF][k*16 +: 16] = 16'hC000 + 16'(k);
            mem[12'h000][k*16 +: 16] = 16'hD000 + 16'(k);
        end

        #1;
        check("rst_emif_address", {116'd0, emif_address}, 128'd0);
        check("rst_buf_addr", {120'd0, buf_addr}, 128'd0);
        check("rst_buf_datain", {112'd0, buf_datain}, 128'd0);
        check("rst_buf_wen", {127'd0, buf_wen}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("emif_wen", {127'd0, emif_wen}, 128'd0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", {112'd0, checksum}, 128'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_load("full_line", 12'h010, 8'h00, 8, 1'b1);
        run_load("two_lines", 12'h020, 8'h40, 10, 1'b0);
        run_load("buf_wrap", 12'h020, 8'hFE, 4, 1'b0);
        run_load("emif_wrap", 12'hFFF, 8'h10, 9, 1'b0);
        run_load("zero_len", 12'h010, 8'h20, 0, 1'b0);

        // Abort a load with reset during cycle 5.
        push_expected(12'h010, 8'h60, 8, sum);
        @(negedge clk);
        emif_base = 12'h010; buf_base = 8'h60; num_words = 9'd8; start = 1'b1;
        cyc = 0;
        while (cyc < 5) begin
            @(posedge clk);
            cyc++;
            #1 start = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        check("abort_buf_wen", {127'd0, buf_wen}, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 128'(dones), 128'd0);
        check("abort_writes_left", 128'(q.size()), 128'd5);
        q.delete();
        reset = 1'b0;

        run_load("after_abort", 12'h010, 8'h80, 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
